// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiplier and restoring divider
// sharing one 2*XLEN accumulator, with an optional single-cycle path for div-by-zero/overflow.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | one shift-add or restoring-subtract step per cycle, XLEN cycles
// DONE  | result held on out until out_ready
module muldiv_unit #(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      funct_3,
    input  logic            flush,
    output logic [XLEN-1:0] out,
    output logic            out_valid,
    input  logic            out_ready
);
    localparam int CW = $clog2(XLEN);
    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic            neg_res;
    logic [XLEN-1:0] opb;
    logic [W2-1:0]   acc;

    logic            is_div, sa, sb, dz, ovf, special, neg_in;
    logic [XLEN-1:0] mag1, mag2, special_res;
    logic [XLEN:0]   sum, shifted;
    logic [XLEN-1:0] diff, div_sel, div_res, mul_res, final_res;
    logic            ge;
    logic [W2-1:0]   mul_next, div_next, step_next, prod;

    // Operand preparation: signed operands are reduced to magnitudes, the sign fix is applied at the end.
    always_comb begin
        is_div  = funct_3[2];
        sa      = in1[XLEN-1] & (is_div ? ~funct_3[0] : (funct_3[1] ^ funct_3[0]));
        sb      = in2[XLEN-1] & (is_div ? ~funct_3[0] : (funct_3[1:0] == 2'b01));
        mag1    = sa ? (~in1 + XLEN'(1)) : in1;
        mag2    = sb ? (~in2 + XLEN'(1)) : in2;
        dz      = is_div && (in2 == '0);
        ovf     = is_div && !funct_3[0] && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
        special = (FAST_SPECIAL != 0) && (dz || ovf);
        if (dz)
            special_res = funct_3[1] ? in1 : '1;
        else
            special_res = funct_3[1] ? '0 : in1;
        // A zero divisor counts as positive, so its quotient is never negated.
        if (is_div)
            neg_in = funct_3[1] ? sa : ((sa ^ sb) && !dz);
        else
            neg_in = sa ^ sb;
    end

    always_comb begin
        sum       = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next  = {sum, acc[XLEN-1:1]};
        shifted   = {acc[W2-1:XLEN], acc[XLEN-1]};
        ge        = (shifted >= {1'b0, opb});
        diff      = shifted[XLEN-1:0] - opb;
        div_next  = ge ? {diff, acc[XLEN-2:0], 1'b1}
                       : {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        step_next = op[2] ? div_next : mul_next;
        prod      = neg_res ? (~step_next + W2'(1)) : step_next;
        mul_res   = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
        div_sel   = op[1] ? step_next[W2-1:XLEN] : step_next[XLEN-1:0];
        div_res   = neg_res ? (~div_sel + XLEN'(1)) : div_sel;
        final_res = op[2] ? div_res : mul_res;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            cnt       <= '0;
            op        <= '0;
            neg_res   <= 1'b0;
            opb       <= '0;
            acc       <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op       <= funct_3;
                        neg_res  <= neg_in;
                        cnt      <= CW'(XLEN - 1);
                        in_ready <= 1'b0;
                        if (is_div) begin
                            acc <= {{XLEN{1'b0}}, mag1};
                            opb <= mag2;
                        end else begin
                            acc <= {{XLEN{1'b0}}, mag2};
                            opb <= mag1;
                        end
                        if (special) begin
                            state     <= DONE;
                            out       <= special_res;
                            out_valid <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= step_next;
                    if (cnt == '0) begin
                        state     <= DONE;
                        out       <= final_res;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out       <= '0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out       <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32, FAST_SPECIAL=1): results, latency,
// back-pressure, flush and mid-operation reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1, in2;
    logic [2:0]  funct_3;
    logic        flush;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .funct_3   (funct_3),
        .flush     (flush),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        funct_3  = f;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1      = ~a;
        in2      = ~b;
        funct_3  = ~f;
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_v, input int exp_lat);
        int lat;
        bit busy_bad;
        issue(f, a, b);
        lat = 0;
        busy_bad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (out_valid !== 1'b1 && out !== 32'h0) busy_bad = 1'b1;
            if (in_ready !== 1'b0) busy_bad = 1'b1;
        end while (out_valid !== 1'b1 && lat < 100);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " out"}, 64'(out), 64'(exp_v));
        check({tag, " busy"}, 64'(busy_bad), 64'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, " drain"}, 64'({in_ready, out_valid, out}), {30'h0, 1'b1, 1'b0, 32'h0});
    endtask

    initial begin
        int  n;
        bit  bad;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        funct_3   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 64'({in_ready, out_valid, out}), {30'h0, 1'b1, 1'b0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;

        do_op("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        do_op("MUL 2^16*2^16",   3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 33);
        do_op("MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        do_op("MULH -1*1",       3'b001, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33);
        do_op("MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        do_op("MULHSU -1*max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        do_op("DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        do_op("REM -7/2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        do_op("DIV 7/-2",        3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        do_op("REM 7/-2",        3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
        do_op("DIV -7/-2",       3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 33);
        do_op("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14,       33);
        do_op("REMU 100/7",      3'b111, 32'd100,      32'd7,        32'd2,        33);
        do_op("DIVU max/16",     3'b101, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 33);
        do_op("REMU max/16",     3'b111, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 33);
        do_op("DIV 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        do_op("REM 5/0",         3'b110, 32'd5,        32'd0,        32'd5,        1);
        do_op("REM -7/0",        3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
        do_op("DIVU 7/0",        3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, 1);
        do_op("REMU 7/0",        3'b111, 32'd7,        32'd0,        32'd7,        1);
        do_op("DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // Back-pressure: result must hold for 10 cycles, and the consume edge must not accept.
        issue(3'b000, 32'd6, 32'd7);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < 100);
        check("stall latency", 64'(n), 64'd33);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out !== 32'd42 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        end
        check("stall hold", 64'(bad), 64'h0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        funct_3   = 3'b000;
        in1       = 32'd9;
        in2       = 32'd9;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("stall release", 64'({in_ready, out_valid, out}), {30'h0, 1'b1, 1'b0, 32'h0});
        in_valid = 1'b0;
        @(negedge clk);
        check("no accept on consume", 64'({in_ready, out_valid}), 64'h2);

        // Flush at CALC cycle 10 with a competing request.
        issue(3'b101, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        funct_3  = 3'b000;
        in1      = 32'd3;
        in2      = 32'd4;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush ready", 64'({in_ready, out_valid, out}), {30'h0, 1'b1, 1'b0, 32'h0});
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        check("flush no result", 64'(bad), 64'h0);
        do_op("post flush MUL", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // Reset at CALC cycle 10 with a competing request.
        issue(3'b100, 32'hFFFFFFF9, 32'd2);
        repeat (10) @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        funct_3  = 3'b011;
        in1      = 32'd5;
        in2      = 32'd6;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset ready", 64'({in_ready, out_valid, out}), {30'h0, 1'b1, 1'b0, 32'h0});
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        check("reset no result", 64'(bad), 64'h0);
        do_op("post reset DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand/result width in bits (even, >= 8).
REQ-002 The block SHALL have parameter FAST_SPECIAL, default 1, meaning divide-by-zero/overflow cases complete without iteration when 1.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  operation request.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port in1  input  XLEN  rs1 operand.
REQ-008 The block SHALL have port in2  input  XLEN  rs2 operand.
REQ-009 The block SHALL have port funct_3  input  3  RV32M select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 The block SHALL have port flush  input  1  abort any in-flight operation.
REQ-011 The block SHALL have port out  output  XLEN  result.
REQ-012 The block SHALL have port out_valid  output  1  out holds a completed result.
REQ-013 The block SHALL have port out_ready  input  1  consumer takes the result.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-015 A request SHALL be accepted on the edge where in_valid && in_ready; operands and funct_3 are latched then and later input changes are ignored.
REQ-016 On accept with a normal case, the FSM SHALL go to CALC, load an iteration counter with XLEN-1 and perform one shift-add (multiply) or one restoring-subtract (divide) step per cycle.
REQ-017 CALC SHALL last exactly XLEN cycles, then go to DONE; out_valid SHALL rise XLEN+1 cycles after the accept edge.
REQ-018 Multiply SHALL form the full 2*XLEN product; MUL returns low XLEN bits; MULH, MULHSU, MULHU return high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned operand interpretation.
REQ-019 Signed divide SHALL operate on magnitudes; quotient is negated when operand signs differ; remainder takes the sign of the dividend (truncating division).
REQ-020 Divide by zero SHALL return quotient all-ones (DIV, DIVU) and remainder = in1 (REM, REMU).
REQ-021 Signed overflow (in1 = -2^(XLEN-1), in2 = -1) SHALL return DIV = in1, REM = 0.
REQ-022 With FAST_SPECIAL=1, cases REQ-020/021 SHALL skip CALC, going IDLE->DONE with out_valid one cycle after accept; with FAST_SPECIAL=0 they take normal latency with identical results.
REQ-023 In DONE, out and out_valid SHALL hold stable until out_valid && out_ready, after which the FSM returns to IDLE on that edge (out_valid low next cycle).
REQ-024 No new request SHALL be accepted in the cycle the result is consumed; minimum issue interval is result latency + 1 cycle.
REQ-025 flush SHALL take priority over all other events: on the edge it is sampled high, the FSM goes to IDLE, out_valid clears, and a simultaneous in_valid is not accepted.
REQ-026 out SHALL equal 0 whenever out_valid is 0.
REQ-027 Undefined behaviour SHALL not exist: all 8 funct_3 codes are legal.

Reset
REQ-028 On rst_n low at a clock edge, the FSM SHALL go to IDLE, the counter and all datapath registers clear; next cycle in_ready = 1, out_valid = 0, out = 0.
REQ-029 Reset asserted mid-CALC or in DONE SHALL discard the operation with no result produced.

Verification (XLEN=32)
REQ-030 MUL in1=7, in2=0xFFFFFFFD -> out=0xFFFFFFEB, out_valid exactly 33 cycles after accept.
REQ-031 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-033 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each out_valid one cycle after accept (FAST_SPECIAL=1).
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> out stable, in_ready=0 throughout; raise out_ready -> in_ready=1 next cycle.
REQ-035 Assert flush (or rst_n=0) at CALC cycle 10 with in_valid=1 -> no out_valid ever for that op, in_ready=1 next cycle, following op returns correct result.
